// File: rtl/operand_fetch_unit.sv
// Operand fetch front end for the threaded register file.
// Valid/ready semantics (both interfaces): a transfer happens on a rising edge
// where valid and ready are both high; ready never depends on valid. out_op_*
// hold stable while out_op_valid is high and in_op_ready is low, apart from
// snooped writes, which keep operands equal to the architectural register state.
// Each request issues two reads on the 1-cycle-latency port (rs1 then rs2).
// Writes seen on the snoop port are forwarded when they coincide with or follow
// the read of the matching register.
module operand_fetch_unit #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_req_valid,
  output logic                                      out_req_ready,
  input  logic [THREAD_INDEX_BITS-1:0]              in_req_tid,
  input  logic [REG_INDEX_BITS-1:0]                 in_req_rs1,
  input  logic [REG_INDEX_BITS-1:0]                 in_req_rs2,
  output logic [THREAD_INDEX_BITS+REG_INDEX_BITS-1:0] out_rf_raddr,
  input  logic [DATA_WIDTH-1:0]                     in_rf_rdata,
  input  logic                                      in_wb_we,
  input  logic [THREAD_INDEX_BITS+REG_INDEX_BITS-1:0] in_wb_waddr,
  input  logic [DATA_WIDTH-1:0]                     in_wb_wdata,
  output logic                                      out_op_valid,
  input  logic                                      in_op_ready,
  output logic [DATA_WIDTH-1:0]                     out_op_a,
  output logic [DATA_WIDTH-1:0]                     out_op_b,
  output logic [THREAD_INDEX_BITS-1:0]              out_op_tid,
  output logic [2:0]                                dbg_state
);

  localparam int AW = THREAD_INDEX_BITS + REG_INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_A = 3'd1,
    ISSUE_B = 3'd2,
    CAP_B   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic [THREAD_INDEX_BITS-1:0]   tid_q;
  logic [REG_INDEX_BITS-1:0]      rs1_q;
  logic [REG_INDEX_BITS-1:0]      rs2_q;
  logic                           fwd_a;
  logic                           fwd_b;
  logic [DATA_WIDTH-1:0]          fwd_a_val;
  logic [DATA_WIDTH-1:0]          fwd_b_val;
  logic [AW-1:0]                  addr_a;
  logic [AW-1:0]                  addr_b;
  logic                           match_a;
  logic                           match_b;
  logic                           accept;

  assign addr_a  = {tid_q, rs1_q};
  assign addr_b  = {tid_q, rs2_q};
  // Full {tid,reg} compare: other threads never match, register 0 is ordinary.
  assign match_a = in_wb_we && (in_wb_waddr == addr_a);
  assign match_b = in_wb_we && (in_wb_waddr == addr_b);

  assign out_req_ready = (state_q == IDLE) || ((state_q == DONE) && in_op_ready);
  assign accept        = in_req_valid && out_req_ready;
  assign out_op_valid  = (state_q == DONE);
  assign dbg_state     = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed four-cycle walk, DONE waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE_A;
      ISSUE_A: state_d = ISSUE_B;
      ISSUE_B: state_d = CAP_B;
      CAP_B:   state_d = DONE;
      DONE:    if (in_op_ready) state_d = accept ? ISSUE_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and read-address sequencing (rs1 on accept, rs2 in ISSUE_A).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      out_rf_raddr <= '0;
    end else if (accept) begin
      tid_q        <= in_req_tid;
      rs1_q        <= in_req_rs1;
      rs2_q        <= in_req_rs2;
      out_rf_raddr <= {in_req_tid, in_req_rs1};
    end else if (state_q == ISSUE_A) begin
      out_rf_raddr <= addr_b;
    end
  end

  // Forward flags: catch a write landing on the same edge the register file
  // samples our address, since the port then returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a     <= 1'b0;
      fwd_b     <= 1'b0;
      fwd_a_val <= '0;
      fwd_b_val <= '0;
    end else if (accept) begin
      fwd_a <= 1'b0;
      fwd_b <= 1'b0;
    end else if ((state_q == ISSUE_A) && match_a) begin
      fwd_a     <= 1'b1;
      fwd_a_val <= in_wb_wdata;
    end else if ((state_q == ISSUE_B) && match_b) begin
      fwd_b     <= 1'b1;
      fwd_b_val <= in_wb_wdata;
    end
  end

  // Operand capture and tracking: newest write beats forwarded value beats RF data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_op_a   <= '0;
      out_op_b   <= '0;
      out_op_tid <= '0;
    end else begin
      case (state_q)
        ISSUE_B: begin
          out_op_a <= match_a ? in_wb_wdata : (fwd_a ? fwd_a_val : in_rf_rdata);
        end
        CAP_B: begin
          out_op_b   <= match_b ? in_wb_wdata : (fwd_b ? fwd_b_val : in_rf_rdata);
          if (match_a) out_op_a <= in_wb_wdata;
          out_op_tid <= tid_q;
        end
        DONE: begin
          // Values presented in the handshake cycle are final.
          if (!in_op_ready) begin
            if (match_a) out_op_a <= in_wb_wdata;
            if (match_b) out_op_b <= in_wb_wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a behavioural 1-cycle-latency
// register file (read returns pre-write data on a same-edge write).
module tb_operand_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        in_req_valid;
  logic        out_req_ready;
  logic [2:0]  in_req_tid;
  logic [4:0]  in_req_rs1;
  logic [4:0]  in_req_rs2;
  logic [7:0]  out_rf_raddr;
  logic [63:0] in_rf_rdata;
  logic        in_wb_we;
  logic [7:0]  in_wb_waddr;
  logic [63:0] in_wb_wdata;
  logic        out_op_valid;
  logic        in_op_ready;
  logic [63:0] out_op_a;
  logic [63:0] out_op_b;
  logic [2:0]  out_op_tid;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cur_vec = -1;

  operand_fetch_unit #(
    .DATA_WIDTH(64), .REG_INDEX_BITS(5), .THREAD_INDEX_BITS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
    .in_req_tid(in_req_tid), .in_req_rs1(in_req_rs1), .in_req_rs2(in_req_rs2),
    .out_rf_raddr(out_rf_raddr), .in_rf_rdata(in_rf_rdata),
    .in_wb_we(in_wb_we), .in_wb_waddr(in_wb_waddr), .in_wb_wdata(in_wb_wdata),
    .out_op_valid(out_op_valid), .in_op_ready(in_op_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_op_tid(out_op_tid),
    .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model.
  logic [63:0] rf_mem [256];
  always @(posedge clk) begin
    in_rf_rdata <= rf_mem[out_rf_raddr];
    if (in_wb_we) rf_mem[in_wb_waddr] <= in_wb_wdata;
  end

  typedef struct {
    logic [2:0]  tid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] pre_a;
    logic [63:0] pre_b;
    int          wr_cyc;   // cycle (0 = accept) of the snooped write, -1 none
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d) t=%0t: got 0x%0h expected 0x%0h", name, cur_vec, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_write(input logic [7:0] addr, input logic [63:0] data);
    in_wb_we    = 1'b1;
    in_wb_waddr = addr;
    in_wb_wdata = data;
    next_cycle();
    in_wb_we    = 1'b0;
  endtask

  // Drive one request with in_op_ready=1; cycle k=0 is the accept cycle.
  task automatic run_vec(input vec_t v);
    rf_write({v.tid, v.rs1}, v.pre_a);
    rf_write({v.tid, v.rs2}, v.pre_b);
    for (int k = 0; k < 5; k++) begin
      in_req_valid = (k == 0);
      in_req_tid   = v.tid;
      in_req_rs1   = v.rs1;
      in_req_rs2   = v.rs2;
      in_wb_we     = (k == v.wr_cyc);
      in_wb_waddr  = v.wr_addr;
      in_wb_wdata  = v.wr_data;
      in_op_ready  = 1'b1;
      @(negedge clk);
      case (k)
        0: check("req_ready_idle", 64'(out_req_ready), 64'd1);
        1: check("raddr_a", 64'(out_rf_raddr), 64'({v.tid, v.rs1}));
        2: begin
          check("raddr_b", 64'(out_rf_raddr), 64'({v.tid, v.rs2}));
          check("req_ready_busy", 64'(out_req_ready), 64'd0);
        end
        3: check("valid_early", 64'(out_op_valid), 64'd0);
        default: begin
          check("valid_c4", 64'(out_op_valid), 64'd1);
          check("op_a", out_op_a, v.exp_a);
          check("op_b", out_op_b, v.exp_b);
          check("op_tid", 64'(out_op_tid), 64'(v.tid));
          check("req_ready_done", 64'(out_req_ready), 64'd1);
        end
      endcase
      next_cycle();
    end
    in_req_valid = 1'b0;
    in_wb_we     = 1'b0;
    @(negedge clk);
    check("valid_after", 64'(out_op_valid), 64'd0);
    next_cycle();
  endtask

  initial begin
    // Vector table: preload, optional snooped write, expected operands.
    vecs[0]  = '{3'd3, 5'd5, 5'd7, 64'hAAAA, 64'hBBBB, -1, 8'h00, 64'h0,    64'hAAAA, 64'hBBBB};
    vecs[1]  = '{3'd3, 5'd5, 5'd7, 64'hAAAA, 64'hBBBB,  1, 8'h65, 64'h1234, 64'h1234, 64'hBBBB};
    vecs[2]  = '{3'd3, 5'd5, 5'd7, 64'hAAAA, 64'hBBBB,  2, 8'h67, 64'h5678, 64'hAAAA, 64'h5678};
    vecs[3]  = '{3'd3, 5'd5, 5'd7, 64'hAAAA, 64'hBBBB,  3, 8'h67, 64'h9ABC, 64'hAAAA, 64'h9ABC};
    vecs[4]  = '{3'd3, 5'd5, 5'd7, 64'hAAAA, 64'hBBBB,  2, 8'h65, 64'h4242, 64'h4242, 64'hBBBB};
    vecs[5]  = '{3'd3, 5'd5, 5'd7, 64'hAAAA, 64'hBBBB,  3, 8'h65, 64'h3333, 64'h3333, 64'hBBBB};
    vecs[6]  = '{3'd3, 5'd5, 5'd7, 64'hAAAA, 64'hBBBB,  1, 8'h67, 64'h7777, 64'hAAAA, 64'h7777};
    vecs[7]  = '{3'd3, 5'd5, 5'd7, 64'hAAAA, 64'hBBBB,  0, 8'h65, 64'h5555, 64'h5555, 64'hBBBB};
    vecs[8]  = '{3'd1, 5'd9, 5'd9, 64'h11,   64'h11,    3, 8'h29, 64'h99,   64'h99,   64'h99};
    vecs[9]  = '{3'd1, 5'd9, 5'd9, 64'h11,   64'h11,    3, 8'h49, 64'h77,   64'h11,   64'h11};
    vecs[10] = '{3'd1, 5'd9, 5'd9, 64'h11,   64'h11,    1, 8'h29, 64'h88,   64'h88,   64'h88};
    vecs[11] = '{3'd0, 5'd0, 5'd3, 64'hF0,   64'hF3,    1, 8'h00, 64'hDEAD, 64'hDEAD, 64'hF3};
    vecs[12] = '{3'd7, 5'd31, 5'd30, 64'hFF, 64'hFE,    2, 8'hDF, 64'hE0,   64'hFF,   64'hFE};

    // Reset.
    rst_n = 1'b0; in_req_valid = 1'b0; in_req_tid = '0; in_req_rs1 = '0; in_req_rs2 = '0;
    in_wb_we = 1'b0; in_wb_waddr = '0; in_wb_wdata = '0; in_op_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(out_op_valid), 64'd0);
    check("rst_raddr", 64'(out_rf_raddr), 64'd0);
    check("rst_a", out_op_a, 64'd0);
    check("rst_b", out_op_b, 64'd0);
    check("rst_tid", 64'(out_op_tid), 64'd0);
    check("rst_ready", 64'(out_req_ready), 64'd1);
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Consumer stall with a write to rs2 while holding.
    cur_vec = 100;
    rf_write(8'h65, 64'hAAAA);
    rf_write(8'h67, 64'hBBBB);
    in_op_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_req_valid = (k == 0);
      in_req_tid = 3'd3; in_req_rs1 = 5'd5; in_req_rs2 = 5'd7;
      in_wb_we = (k == 5); in_wb_waddr = 8'h67; in_wb_wdata = 64'hCAFE;
      in_op_ready = (k == 7);
      @(negedge clk);
      if (k == 4) begin
        check("stall_valid4", 64'(out_op_valid), 64'd1);
        check("stall_ready4", 64'(out_req_ready), 64'd0);
        check("stall_b4", out_op_b, 64'hBBBB);
      end
      if (k == 5) check("stall_b5", out_op_b, 64'hBBBB);
      if (k == 6) begin
        check("stall_b6", out_op_b, 64'hCAFE);
        check("stall_a6", out_op_a, 64'hAAAA);
      end
      if (k == 7) begin
        check("stall_valid7", 64'(out_op_valid), 64'd1);
        check("stall_b7", out_op_b, 64'hCAFE);
        check("stall_ready7", 64'(out_req_ready), 64'd1);
      end
      if (k == 8) check("stall_valid8", 64'(out_op_valid), 64'd0);
      next_cycle();
    end
    in_wb_we = 1'b0;

    // Back-to-back: second request accepted in the handshake cycle.
    cur_vec = 101;
    rf_write(8'h65, 64'hAAAA);
    rf_write(8'h67, 64'hBBBB);
    rf_write(8'h41, 64'h21);
    rf_write(8'h42, 64'h22);
    for (int k = 0; k < 10; k++) begin
      in_req_valid = (k == 0) || (k == 4);
      in_req_tid   = (k == 0) ? 3'd3 : 3'd2;
      in_req_rs1   = (k == 0) ? 5'd5 : 5'd1;
      in_req_rs2   = (k == 0) ? 5'd7 : 5'd2;
      in_op_ready  = 1'b1;
      @(negedge clk);
      if (k == 4) begin
        check("b2b_valid4", 64'(out_op_valid), 64'd1);
        check("b2b_ready4", 64'(out_req_ready), 64'd1);
        check("b2b_a4", out_op_a, 64'hAAAA);
        check("b2b_b4", out_op_b, 64'hBBBB);
      end
      if (k >= 5 && k <= 7) check("b2b_valid_gap", 64'(out_op_valid), 64'd0);
      if (k == 5) check("b2b_raddr5", 64'(out_rf_raddr), 64'h41);
      if (k == 6) check("b2b_raddr6", 64'(out_rf_raddr), 64'h42);
      if (k == 8) begin
        check("b2b_valid8", 64'(out_op_valid), 64'd1);
        check("b2b_a8", out_op_a, 64'h21);
        check("b2b_b8", out_op_b, 64'h22);
        check("b2b_tid8", 64'(out_op_tid), 64'd2);
      end
      if (k == 9) check("b2b_valid9", 64'(out_op_valid), 64'd0);
      next_cycle();
    end

    // Reset mid-request: nothing emitted.
    cur_vec = 102;
    for (int k = 0; k < 8; k++) begin
      in_req_valid = (k == 0);
      in_req_tid = 3'd3; in_req_rs1 = 5'd5; in_req_rs2 = 5'd7;
      in_op_ready = 1'b1;
      if (k == 2) rst_n = 1'b0;
      if (k == 3) rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_valid", 64'(out_op_valid), 64'd0);
      if (k == 2) check("rstmid_raddr2", 64'(out_rf_raddr), 64'd0);
      if (k == 3) begin
        check("rstmid_ready", 64'(out_req_ready), 64'd1);
        check("rstmid_raddr3", 64'(out_rf_raddr), 64'd0);
        check("rstmid_a", out_op_a, 64'd0);
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Front end that drives the single read port of the threaded register file.
- Accepts an operand request (thread id, rs1, rs2) and issues two sequential reads over the 1-cycle-latency port.
- Snoops the register-file write port and forwards write data for read-during-write and late writes.
- Presents both operands on a valid/ready interface to the execute stage.

Parameters:
DATA_WIDTH, 64, operand / register width
REG_INDEX_BITS, 5, register index width per thread
THREAD_INDEX_BITS, 3, thread id width; register-file address = {tid, reg}

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_req_valid  in  1  operand request valid
out_req_ready  out  1  request accepted when valid & ready
in_req_tid  in  THREAD_INDEX_BITS  thread id
in_req_rs1  in  REG_INDEX_BITS  source register A
in_req_rs2  in  REG_INDEX_BITS  source register B
out_rf_raddr  out  THREAD_INDEX_BITS+REG_INDEX_BITS  registered read address to register file
in_rf_rdata  in  DATA_WIDTH  register-file read data (valid one cycle after address sampled)
in_wb_we  in  1  snoop: register-file write enable
in_wb_waddr  in  THREAD_INDEX_BITS+REG_INDEX_BITS  snoop: write address
in_wb_wdata  in  DATA_WIDTH  snoop: write data
out_op_valid  out  1  operands valid
in_op_ready  in  1  consumer ready
out_op_a  out  DATA_WIDTH  value of {tid,rs1}
out_op_b  out  DATA_WIDTH  value of {tid,rs2}
out_op_tid  out  THREAD_INDEX_BITS  thread id of operands

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - out_op_valid=0; out_rf_raddr=0; out_op_a/b=0; out_op_tid=0.
  - Forward flags cleared.
  - A request in flight is discarded and produces no output.
- FSM states: IDLE, ISSUE_A, ISSUE_B, CAP_B, DONE.
- out_req_ready = (state==IDLE) | (state==DONE & in_op_ready). Combinational; no other dependency on in_req_valid.
- Accept (cycle 0):
  - Latch tid, rs1, rs2.
  - out_rf_raddr <= {tid,rs1}.
  - Go to ISSUE_A.
- ISSUE_A (cycle 1):
  - out_rf_raddr <= {tid,rs2}.
  - If in_wb_we and waddr=={tid,rs1}: set fwd_a, fwd_a_val<=wdata. This covers the register file returning old data on same-edge write.
  - Go to ISSUE_B.
- ISSUE_B (cycle 2):
  - A capture: out_op_a <= match_a ? wdata : fwd_a ? fwd_a_val : in_rf_rdata.
  - B issue-cycle snoop, identical to ISSUE_A rule, into fwd_b.
  - Go to CAP_B.
- CAP_B (cycle 3):
  - B capture, same priority as A.
  - A tracking: out_op_a <= match_a ? wdata : out_op_a.
  - Go to DONE; out_op_valid=1 from cycle 4.
- Latency: accept to out_op_valid = 4 cycles. Max throughput 1 request / 4 cycles.
- DONE:
  - Operands and tid held stable except for snoop updates. Each cycle a matching write updates the operand at the next edge, so operands always equal register state as of the cycle start.
  - On in_op_ready: handshake completes; values presented in that cycle are final, and a same-cycle write is not reflected.
  - Next state: ISSUE_A if a new request is accepted the same cycle, else IDLE; out_op_valid drops unless re-entering DONE later.
- Match rules:
  - Compare the full {tid,reg} address; writes to another thread never match.
  - rs1==rs2 is legal; each operand forwards independently.
  - Register 0 is not special (no hardwired zero).
- Forward flags clear on accept of a new request.
- in_req_* are ignored when out_req_ready=0.

Test Plan:
1. Preload {3,r5}=0xAAAA, {3,r7}=0xBBBB; request tid=3 rs1=5 rs2=7 in cycle 0, in_op_ready=1 -> out_rf_raddr 0x65 in cycle 1, 0x67 in cycle 2; out_op_valid=1 in cycle 4 with a=0xAAAA, b=0xBBBB, tid=3; out_req_ready=1 in cycle 4.
2. Same request, write {3,r5}=0x1234 in cycle 1 (same-edge read/write) -> a=0x1234, b=0xBBBB.
3. Same request with in_op_ready=0 until cycle 7; write {3,r7}=0xCAFE in cycle 5 -> b=0xBBBB in cycle 5, b=0xCAFE from cycle 6, handed off in cycle 7; out_op_valid=0 in cycle 8.
4. rs1=rs2=9, tid=1, {1,r9}=0x11; write {1,r9}=0x99 in cycle 3 -> a=b=0x99 at cycle 4; write {2,r9}=0x77 in cycle 3 -> no effect (a=b=0x11).
5. Back-to-back: second request presented in cycle 4 with in_op_ready=1 -> accepted in cycle 4; out_op_valid low in cycles 5-7; second operands valid in cycle 8.
6. rst_n pulled low in cycle 2 mid-request, released in cycle 3 -> out_op_valid stays 0, out_rf_raddr=0, out_req_ready=1 after release; no operands emitted.
